// File: rtl/gcd_pkg.sv
// gcd_pkg: shared definitions for the iterative GCD engine.
// Holds the controller state encodings and the state enum used by gcd_engine.
package gcd_pkg;

  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_CALC = 2'd1;
  localparam logic [1:0] ENC_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ENC_IDLE,
    CALC = ENC_CALC,
    DONE = ENC_DONE
  } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational iteration of subtractive GCD.
// Ports:
//   a, b       current operand registers
//   a_nxt      next A (A-B when A>B, else A unchanged)
//   b_nxt      next B (B-A when B>A, else B unchanged)
//   term       iteration terminates this cycle
//   both_zero  terminated because both operands are zero
//   result     GCD value, meaningful only when term=1
module gcd_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             term,
  output logic             both_zero,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    a_nxt     = a;
    b_nxt     = b;
    term      = 1'b0;
    both_zero = 1'b0;
    result    = '0;
    if (a == '0 && b == '0) begin
      term      = 1'b1;
      both_zero = 1'b1;
    end else if (a == '0 || b == '0) begin
      // one side is zero, so the OR is simply the non-zero operand
      term   = 1'b1;
      result = a | b;
    end else if (a == b) begin
      term   = 1'b1;
      result = a;
    end else if (a > b) begin
      a_nxt = a - b;
    end else begin
      b_nxt = b - a;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: iterative subtractive GCD with start/busy/done handshake.
// Optional feature macro: GCD_CYCLE_COUNT_EN adds the 'cycles' output.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only in IDLE or DONE
//   a_in,b_in operands, captured with an accepted start
//   busy      high while computing (CALC)
//   done      high in DONE, held until next accepted start or rst
//   gcd_out   result, valid while done=1
//   zero_err  high with done when both operands were zero
//   cycles    CALC cycle count, frozen in DONE (GCD_CYCLE_COUNT_EN only)
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err
`ifdef GCD_CYCLE_COUNT_EN
  ,
  output logic [WIDTH-1:0] cycles
`endif
);

  gcd_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] gcd_q;
  logic             zero_q;
  logic             accept;

  logic [WIDTH-1:0] a_nxt, b_nxt, step_result;
  logic             step_term, step_both_zero;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a         (a_q),
    .b         (b_q),
    .a_nxt     (a_nxt),
    .b_nxt     (b_nxt),
    .term      (step_term),
    .both_zero (step_both_zero),
    .result    (step_result)
  );

  // start is only honoured outside CALC; a request mid-computation is dropped
  assign accept = start && (state_q != CALC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = CALC;
      CALC:       if (step_term) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q    <= a_in;
        b_q    <= b_in;
        zero_q <= 1'b0;
      end else if (state_q == CALC) begin
        a_q <= a_nxt;
        b_q <= b_nxt;
        if (step_term) begin
          gcd_q  <= step_result;
          zero_q <= step_both_zero;
        end
      end
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [WIDTH-1:0] cnt_q;

  // counts every CALC edge including the terminating one; holds in DONE
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (accept)             cnt_q <= '0;
    else if (state_q == CALC)    cnt_q <= cnt_q + 1'b1;
  end

  assign cycles = cnt_q;
`endif

  assign busy     = (state_q == CALC);
  assign done     = (state_q == DONE);
  assign gcd_out  = gcd_q;
  assign zero_err = zero_q;

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed, table-driven bench for gcd_engine (WIDTH=16 and WIDTH=8).
module tb_gcd_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        busy, done, zero_err;
  logic [15:0] gcd_out;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8;
  logic [7:0]  gcd8;

`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0] cycles;
  logic [7:0]  cycles8;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .gcd_out(gcd_out), .zero_err(zero_err)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles)
`endif
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
    .busy(busy8), .done(done8), .gcd_out(gcd8), .zero_err(zero8)
`ifdef GCD_CYCLE_COUNT_EN
    , .cycles(cycles8)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] g;
    logic        z;
    int          n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // drive a start pulse; returns 1 time unit after the accepting edge
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // count edges after the accepting edge until done, bounded
  task automatic wait_done(input int n0, input int limit, output int n);
    n = n0;
    while (!done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (busy && done) chk("busy_done_exclusive", 1, 0);
    end
    if (!done) chk("timeout", 0, 1);
  endtask

  initial begin
    int n;
    vecs[0] = '{a:16'd48,  b:16'd18,  g:16'd6,  z:1'b0, n:5};
    vecs[1] = '{a:16'd7,   b:16'd7,   g:16'd7,  z:1'b0, n:1};
    vecs[2] = '{a:16'd0,   b:16'd9,   g:16'd9,  z:1'b0, n:1};
    vecs[3] = '{a:16'd9,   b:16'd0,   g:16'd9,  z:1'b0, n:1};
    vecs[4] = '{a:16'd0,   b:16'd0,   g:16'd0,  z:1'b1, n:1};
    vecs[5] = '{a:16'd21,  b:16'd14,  g:16'd7,  z:1'b0, n:3};
    vecs[6] = '{a:16'd100, b:16'd10,  g:16'd10, z:1'b0, n:10};
    vecs[7] = '{a:16'd13,  b:16'd8,   g:16'd1,  z:1'b0, n:6};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_gcd", gcd_out, 0);
    chk("rst_zero", zero_err, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("rst_cycles", cycles, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_busy_after_start", i), busy, 1);
      chk($sformatf("v%0d_done_low", i), done, 0);
      wait_done(0, 1000, n);
      chk($sformatf("v%0d_latency", i), n, vecs[i].n);
      chk($sformatf("v%0d_gcd", i), gcd_out, vecs[i].g);
      chk($sformatf("v%0d_zero_err", i), zero_err, vecs[i].z);
      chk($sformatf("v%0d_busy_in_done", i), busy, 0);
`ifdef GCD_CYCLE_COUNT_EN
      chk($sformatf("v%0d_cycles", i), cycles, vecs[i].n);
`endif
    end

    // done and result hold while start stays low
    repeat (3) @(posedge clk);
    #1;
    chk("hold_done", done, 1);
    chk("hold_gcd", gcd_out, 1);
`ifdef GCD_CYCLE_COUNT_EN
    chk("hold_cycles", cycles, 6);
`endif

    // start during CALC is ignored
    start_op(16'd48, 16'd18);
    @(posedge clk); #1;
    a_in = 16'd100; b_in = 16'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2, 1000, n);
    chk("ign_latency", n, 5);
    chk("ign_gcd", gcd_out, 6);
`ifdef GCD_CYCLE_COUNT_EN
    chk("ign_cycles", cycles, 5);
`endif

    // back-to-back restart from DONE
    start_op(16'd100, 16'd10);
    chk("b2b_done_drop", done, 0);
    chk("b2b_busy", busy, 1);
    wait_done(0, 1000, n);
    chk("b2b_latency", n, 10);
    chk("b2b_gcd", gcd_out, 10);

    // reset mid-CALC discards everything
    start_op(16'd1000, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_gcd", gcd_out, 0);
    chk("midrst_zero", zero_err, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("midrst_cycles", cycles, 0);
`endif
    @(posedge clk); #1;
    chk("midrst_stays_idle", busy, 0);
    start_op(16'd21, 16'd14);
    wait_done(0, 1000, n);
    chk("post_rst_gcd", gcd_out, 7);
    chk("post_rst_latency", n, 3);

    // WIDTH=8 worst case
    @(negedge clk);
    a8 = 8'd255; b8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("w8_busy", busy8, 1);
    n = 0;
    while (!done8 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w8_latency", n, 255);
    chk("w8_gcd", gcd8, 1);
    chk("w8_zero", zero8, 0);
`ifdef GCD_CYCLE_COUNT_EN
    chk("w8_cycles", cycles8, 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
